bullet_scheduler: RTL and testbench
===================================

// Module: bullet_scheduler
// PURPOSE
//  Sequencer for the 8-slot bullet table (36-bit entries: [35]active, [34:32]color, [31:16]size, [15:8]x, [7:0]y).
//  Clears the table after reset, advances every active bullet by STEP in y on each frame tick and retires bullets at Y_LIMIT.
//  Accepts spawn requests via valid/ready and writes each into the lowest free slot.
//  Sole writer of the table; VGA and collision readers keep their own read indices.
// PARAMETERS
//  NUM_SLOTS  8    table depth (index width 3; must be a power of 2, <=8)
//  STEP       10   y increment per tick (8-bit)
//  Y_LIMIT    200  retire threshold; Y_LIMIT+STEP must be <=255 (elaboration check)
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  isRun         in   1   game running; gates tick and spawn acceptance
//  tick          in   1   1-cycle frame pulse
//  spawn_valid   in   1   spawn request held until accepted
//  spawn_ready   out  1   1-cycle accept pulse
//  spawn_entry   in   35  {color[2:0], size[15:0], x[7:0], y[7:0]}; active bit implied 1
//  rd_index      out  3   table read index (asynchronous read)
//  rd_data       in   36  table word at rd_index, same cycle
//  wr_en         out  1   table write strobe
//  wr_index      out  3   table write index
//  wr_data       out  36  table write word
//  active_count  out  4   number of active slots, updated at end of each sweep/spawn
//  busy          out  1   FSM not in IDLE
//  overrun       out  1   sticky: tick arrived while one tick already pending
// BEHAVIOUR
//  Reset: state=CLEAR, slot counter=0, wr_en=0, spawn_ready=0, pending=0, overrun=0, active_count=0, busy=1.
//  States: CLEAR, IDLE, SWEEP, SCAN, SPAWN.
//  CLEAR: NUM_SLOTS cycles, wr_en=1, wr_index=i, wr_data=0; then IDLE. Reset mid-operation restarts CLEAR.
//  IDLE: if isRun && (tick||pending) -> SWEEP (clears pending); else if isRun && spawn_valid -> SCAN. Tick wins when both.
//  SWEEP: one slot per cycle, i=0..NUM_SLOTS-1, rd_index=i. If rd_data[35]=0: wr_en=0.
//   If active and y>=Y_LIMIT: write with [35]=0, y=0, other fields unchanged (retire).
//   Else: write with y=y+STEP (8-bit, cannot overflow given check). Last slot -> IDLE; active_count=count of survivors.
//  SCAN: rd_index=i from 0; first slot with rd_data[35]=0 -> SPAWN with that index latched.
//   No free slot after NUM_SLOTS cycles -> IDLE, no ready pulse; request stays pending and is retried from IDLE.
//  SPAWN: wr_en=1, wr_data={1'b1, spawn_entry}, spawn_ready=1 for this one cycle, active_count+1; -> IDLE.
//  tick during CLEAR/SWEEP/SCAN/SPAWN with isRun=1: pending<=1; if pending already 1, overrun<=1 (sticky until reset).
//  isRun=0: new ticks ignored and not latched; no new spawn accepted; in-flight sweep/scan/spawn completes.
//  spawn_valid dropped during SCAN: scan completes, SPAWN not entered (ready never pulses without valid).
//  Outputs registered except rd_index/wr_* which are decoded from state + counter; wr_en=0 in IDLE.
//  Latency: tick-to-sweep-complete = NUM_SLOTS+1 cycles from IDLE; spawn accept = 1 + (first free index+1) + 1 cycles.
// TESTING
//  Reset with garbage in table -> 8 cycles of wr_en=1, wr_data=0, idx 0..7; busy falls cycle 9; active_count=0.
//  Spawn {color=001,size=0x1010,x=0x40,y=0x13} on empty table -> written to slot 0 with bit35=1; ready pulses once; count=1.
//  Slot 0 y=0x13, one tick -> slot 0 y=0x1D; slot 0 y=200 (0xC8), tick -> bit35=0, y=0, count=0.
//  Fill all 8 slots, hold spawn_valid -> no ready; tick retires slot 5 -> next spawn lands in slot 5.
//  Tick mid-sweep -> second sweep starts right after first; third tick before that -> overrun=1.
//  isRun=0, pulse tick and spawn_valid -> no wr_en, no ready, table unchanged.

Source files
------------

// File: rtl/bullet_scheduler.sv
// bullet_scheduler: clears, sweeps and fills the 8-slot bullet table as its only writer
module bullet_scheduler #(
  parameter int NUM_SLOTS = 8,
  parameter int STEP      = 10,
  parameter int Y_LIMIT   = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isRun,
  input  logic        tick,
  input  logic        spawn_valid,
  output logic        spawn_ready,
  input  logic [34:0] spawn_entry,
  output logic [2:0]  rd_index,
  input  logic [35:0] rd_data,
  output logic        wr_en,
  output logic [2:0]  wr_index,
  output logic [35:0] wr_data,
  output logic [3:0]  active_count,
  output logic        busy,
  output logic        overrun
);
  if (Y_LIMIT + STEP > 255 || NUM_SLOTS > 8 || NUM_SLOTS < 1 || (NUM_SLOTS & (NUM_SLOTS - 1)) != 0) begin : g_bad_params
    $error("bullet_scheduler: illegal NUM_SLOTS/STEP/Y_LIMIT");
  end
  typedef enum logic [2:0] {CLEAR, IDLE, SWEEP, SCAN, SPAWN} state_t;
  localparam logic [2:0] LAST  = 3'(NUM_SLOTS - 1);
  localparam logic [7:0] STEP8 = 8'(STEP);
  localparam logic [7:0] YLIM8 = 8'(Y_LIMIT);
  state_t state, next;
  logic [2:0] cnt;
  logic [3:0] surv;
  logic pending, last, retire, survive, go_sweep;
  assign last     = cnt == LAST;
  assign retire   = rd_data[35] && rd_data[7:0] >= YLIM8;
  assign survive  = rd_data[35] && !retire;
  assign go_sweep = isRun && (tick || pending);
  // state register; reset always restarts the table clear
  always_ff @(posedge clk)
    state <= reset ? CLEAR : next;
  // next-state: a due tick beats a spawn request in IDLE
  always_comb begin
    next = state;
    case (state)
      CLEAR:   next = last ? IDLE : CLEAR;
      IDLE:    next = go_sweep ? SWEEP : (isRun && spawn_valid) ? SCAN : IDLE;
      SWEEP:   next = last ? IDLE : SWEEP;
      SCAN:    next = !rd_data[35] ? (spawn_valid ? SPAWN : IDLE) : last ? IDLE : SCAN;
      default: next = IDLE;
    endcase
  end
  // table port decode from state and slot counter; the counter still holds the free slot in SPAWN
  always_comb begin
    rd_index = cnt;
    wr_index = cnt;
    wr_en    = !reset && (state == CLEAR || state == SPAWN || (state == SWEEP && rd_data[35]));
    wr_data  = state == SPAWN ? {1'b1, spawn_entry} :
               state != SWEEP ? '0 :
               retire ? {1'b0, rd_data[34:8], 8'd0} : {rd_data[35:8], rd_data[7:0] + STEP8};
  end
  // slot counter, survivor tally, tick bookkeeping and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      surv         <= '0;
      pending      <= 1'b0;
      overrun      <= 1'b0;
      active_count <= '0;
      spawn_ready  <= 1'b0;
      busy         <= 1'b1;
    end else begin
      cnt         <= next == SPAWN ? cnt : next != state ? '0 : cnt + 3'd1;
      surv        <= state == SWEEP ? surv + {3'd0, survive} : '0;
      spawn_ready <= next == SPAWN;
      busy        <= next != IDLE;
      if (state == SWEEP && last)
        active_count <= surv + {3'd0, survive};
      else if (state == SPAWN)
        active_count <= active_count + 4'd1;
      if (state == IDLE)
        pending <= go_sweep ? 1'b0 : pending;
      else if (isRun && tick) begin
        pending <= 1'b1;
        overrun <= overrun | pending;
      end
    end
  end
endmodule

// File: tb/tb_bullet_scheduler.sv
// tb_bullet_scheduler: directed bench with table model and write scoreboard for bullet_scheduler
module tb_bullet_scheduler;
  logic        clk = 1'b0, reset = 1'b1, isRun = 1'b0, tick = 1'b0, spawn_valid = 1'b0;
  logic [34:0] spawn_entry = '0;
  logic        spawn_ready, wr_en, busy, overrun;
  logic [2:0]  rd_index, wr_index;
  logic [35:0] rd_data, wr_data;
  logic [3:0]  active_count;
  logic [35:0] mem [8];
  logic [35:0] mdl [8];
  logic        poke_en = 1'b0;
  logic [2:0]  poke_idx = '0;
  logic [35:0] poke_val = '0;
  logic [38:0] exp_q [$];
  int checks = 0, errors = 0, ready_cnt = 0;

  bullet_scheduler dut (
    .clk(clk), .reset(reset), .isRun(isRun), .tick(tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_entry(spawn_entry),
    .rd_index(rd_index), .rd_data(rd_data),
    .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
    .active_count(active_count), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  assign rd_data = mem[rd_index];

  always @(posedge clk)
    if (wr_en) mem[wr_index] <= wr_data;
    else if (poke_en) mem[poke_idx] <= poke_val;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (spawn_ready) ready_cnt++;
    if (wr_en) begin
      if (exp_q.size() == 0) chk("unexpected_write", 64'({wr_index, wr_data}), '1);
      else chk("table_write", 64'({wr_index, wr_data}), 64'(exp_q.pop_front()));
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic poke(input int idx, input logic [35:0] val);
    poke_idx = 3'(idx);
    poke_val = val;
    poke_en = 1'b1;
    step(1);
    poke_en = 1'b0;
  endtask

  function automatic int nactive();
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(mdl[i][35]);
    return c;
  endfunction

  function automatic int free_slot();
    for (int i = 0; i < 8; i++) if (!mdl[i][35]) return i;
    return -1;
  endfunction

  task automatic push_sweep();
    for (int i = 0; i < 8; i++)
      if (mdl[i][35]) begin
        if (mdl[i][7:0] >= 8'd200) mdl[i] = {1'b0, mdl[i][34:8], 8'd0};
        else mdl[i][7:0] = mdl[i][7:0] + 8'd10;
        exp_q.push_back({3'(i), mdl[i]});
      end
  endtask

  task automatic do_tick();
    int n = 1;
    push_sweep();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    while (busy && n < 40) begin step(1); n++; end
    chk("tick_latency", 64'(n), 64'd9);
    chk("sweep_active_count", 64'(active_count), 64'(nactive()));
  endtask

  task automatic do_spawn(input logic [34:0] e);
    int n = 0, f, r0;
    f = free_slot();
    mdl[f] = {1'b1, e};
    exp_q.push_back({3'(f), mdl[f]});
    spawn_entry = e;
    spawn_valid = 1'b1;
    r0 = ready_cnt;
    while (!spawn_ready && n < 40) begin step(1); n++; end
    spawn_valid = 1'b0;
    chk("spawn_latency", 64'(n), 64'(f + 2));
    step(1);
    chk("spawn_ready_pulses", 64'(ready_cnt - r0), 64'd1);
    chk("spawn_active_count", 64'(active_count), 64'(nactive()));
    chk("spawn_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] g;
    logic [34:0] e5;
    int n, r0;
    for (int i = 0; i < 8; i++) begin
      g = {$urandom, $urandom};
      g[35] = 1'b1;
      poke(i, g[35:0]);
      mdl[i] = '0;
    end
    chk("reset_busy", 64'(busy), 64'd1);
    chk("reset_active_count", 64'(active_count), 64'd0);
    chk("reset_overrun", 64'(overrun), 64'd0);
    chk("reset_spawn_ready", 64'(spawn_ready), 64'd0);
    chk("reset_wr_en", 64'(wr_en), 64'd0);
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 36'd0});
    reset = 1'b0;
    step(7);
    chk("clear_busy_cycle8", 64'(busy), 64'd1);
    step(1);
    chk("clear_busy_cycle9", 64'(busy), 64'd0);
    chk("clear_active_count", 64'(active_count), 64'd0);
    chk("clear_writes_done", 64'(exp_q.size()), 64'd0);

    isRun = 1'b1;
    do_spawn({3'b001, 16'h1010, 8'h40, 8'h13});
    do_tick();
    chk("slot0_advanced", 64'(mem[0]), 64'({1'b1, 3'b001, 16'h1010, 8'h40, 8'h1D}));
    mdl[0][7:0] = 8'hC8;
    poke(0, mdl[0]);
    do_tick();
    chk("slot0_retired", 64'(mem[0]), 64'({1'b0, 3'b001, 16'h1010, 8'h40, 8'h00}));

    for (int i = 0; i < 8; i++)
      do_spawn({3'(i), 16'(i * 273), 8'(i * 20), 8'(16 + i)});
    e5 = {3'b110, 16'hBEEF, 8'h55, 8'h07};
    spawn_entry = e5;
    spawn_valid = 1'b1;
    r0 = ready_cnt;
    step(30);
    chk("full_no_ready", 64'(ready_cnt - r0), 64'd0);
    mdl[5][7:0] = 8'd200;
    poke(5, mdl[5]);
    push_sweep();
    mdl[5] = {1'b1, e5};
    exp_q.push_back({3'd5, mdl[5]});
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    n = 0;
    while (!spawn_ready && n < 60) begin step(1); n++; end
    chk("refill_ready", 64'(spawn_ready), 64'd1);
    spawn_valid = 1'b0;
    step(1);
    chk("refill_active_count", 64'(active_count), 64'd8);
    chk("refill_slot5", 64'(mem[5]), 64'({1'b1, e5}));
    chk("refill_no_overrun", 64'(overrun), 64'd0);

    mdl[3][7:0] = 8'd199;
    poke(3, mdl[3]);
    push_sweep();
    push_sweep();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(2);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("pending_no_overrun", 64'(overrun), 64'd0);
    step(1);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("overrun_set", 64'(overrun), 64'd1);
    n = 6;
    while (busy && n < 40) begin step(1); n++; end
    chk("first_sweep_end", 64'(n), 64'd9);
    step(1);
    n++;
    chk("second_sweep_start", 64'(busy), 64'd1);
    while (busy && n < 60) begin step(1); n++; end
    chk("second_sweep_end", 64'(n), 64'd18);
    chk("double_sweep_count", 64'(active_count), 64'(nactive()));
    step(3);
    chk("no_third_sweep", 64'(busy), 64'd0);

    isRun = 1'b0;
    r0 = ready_cnt;
    spawn_entry = {3'b111, 16'h7777, 8'h11, 8'h22};
    spawn_valid = 1'b1;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(20);
    spawn_valid = 1'b0;
    chk("halted_no_ready", 64'(ready_cnt - r0), 64'd0);
    chk("halted_idle", 64'(busy), 64'd0);
    isRun = 1'b1;
    step(3);
    chk("halted_tick_not_latched", 64'(busy), 64'd0);
    for (int i = 0; i < 8; i++) chk("table_final", 64'(mem[i]), 64'(mdl[i]));
    chk("overrun_sticky", 64'(overrun), 64'd1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
